// File: rtl/bp_cfg_loader.sv
// Purpose : shadow/active configuration bank; per-field validation, then an atomic commit.
// Latency : a full pass makes the new config visible num_fields_p+2 cycles after the commit write.
// Backpr. : wr_ready_o is low while a CHECK/COMMIT is in flight; the writer holds wr_v_i until ready.
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   wr_v_i/wr_ready_o    write handshake carrying wr_id_i, wr_data_i, wr_commit_i
//   rd_id_i/rd_data_o    combinational read of the active bank
//   cfg_v_o              a validated config has been committed (sticky until reset)
//   busy_o               validation or commit in progress
//   err_o/err_id_o       last commit failed; first failing field id
module bp_cfg_loader #(
  parameter int field_width_p = 16,
  parameter int num_fields_p  = 16,
  parameter logic [num_fields_p-1:0] nz_mask_p   = '1,
  parameter logic [num_fields_p-1:0] pow2_mask_p = '0,
  localparam int lg_fields_lp = (num_fields_p > 1) ? $clog2(num_fields_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     wr_v_i,
  input  logic [lg_fields_lp-1:0]  wr_id_i,
  input  logic [field_width_p-1:0] wr_data_i,
  input  logic                     wr_commit_i,
  output logic                     wr_ready_o,
  input  logic [lg_fields_lp-1:0]  rd_id_i,
  output logic [field_width_p-1:0] rd_data_o,
  output logic                     cfg_v_o,
  output logic                     busy_o,
  output logic                     err_o,
  output logic [lg_fields_lp-1:0]  err_id_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_COMMIT = 2'd2,
    S_ERROR  = 2'd3
  } state_e;

  state_e                   state_q, state_n;
  logic [lg_fields_lp-1:0]  chk_idx_q;
  logic [num_fields_p-1:0]  written_q;
  logic [field_width_p-1:0] shadow_q [num_fields_p];
  logic [field_width_p-1:0] active_q [num_fields_p];
  logic                     cfg_v_q;
  logic [lg_fields_lp-1:0]  err_id_q;

  logic                     wr_fire;
  logic                     wr_id_ok;
  logic                     rd_id_ok;
  logic                     chk_last;
  logic                     fld_fail;
  logic [field_width_p-1:0] cur_val;

  assign wr_ready_o = (state_q == S_IDLE) || (state_q == S_ERROR);
  assign wr_fire    = wr_v_i && wr_ready_o;
  // Out-of-range ids are dropped on both ports; a commit riding on one still counts.
  assign wr_id_ok   = 32'(wr_id_i) < num_fields_p;
  assign rd_id_ok   = 32'(rd_id_i) < num_fields_p;
  assign chk_last   = 32'(chk_idx_q) == (num_fields_p - 1);

  // One field examined per CHECK cycle. Power-of-two test: nonzero with a single bit set.
  always_comb begin
    cur_val  = shadow_q[chk_idx_q];
    fld_fail = 1'b0;
    if (!written_q[chk_idx_q])
      fld_fail = 1'b1;
    if (nz_mask_p[chk_idx_q] && (cur_val == '0))
      fld_fail = 1'b1;
    if (pow2_mask_p[chk_idx_q] &&
        ((cur_val == '0) || ((cur_val & (cur_val - field_width_p'(1))) != '0)))
      fld_fail = 1'b1;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:   if (wr_fire && wr_commit_i) state_n = S_CHECK;
      S_CHECK: begin
        if (fld_fail)      state_n = S_ERROR;
        else if (chk_last) state_n = S_COMMIT;
      end
      S_COMMIT: state_n = S_IDLE;
      S_ERROR:  if (wr_fire) state_n = wr_commit_i ? S_CHECK : S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      chk_idx_q <= '0;
      written_q <= '0;
      cfg_v_q   <= 1'b0;
      err_id_q  <= '0;
      for (int i = 0; i < num_fields_p; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      state_q   <= state_n;
      // Index restarts at 0 whenever CHECK is (re)entered.
      chk_idx_q <= (state_q == S_CHECK) ? chk_idx_q + 1'b1 : '0;

      if (wr_fire && wr_id_ok) begin
        shadow_q[wr_id_i]  <= wr_data_i;
        written_q[wr_id_i] <= 1'b1;
      end

      if ((state_q == S_CHECK) && fld_fail)
        err_id_q <= chk_idx_q;
      else if ((state_q == S_ERROR) && wr_fire)
        err_id_q <= '0;

      // Written mask survives a failed check so a single corrective write can recommit.
      if (state_q == S_COMMIT) begin
        for (int i = 0; i < num_fields_p; i++)
          active_q[i] <= shadow_q[i];
        written_q <= '0;
        cfg_v_q   <= 1'b1;
      end
    end
  end

  assign rd_data_o = rd_id_ok ? active_q[rd_id_i] : '0;
  assign cfg_v_o   = cfg_v_q;
  assign busy_o    = (state_q == S_CHECK) || (state_q == S_COMMIT);
  assign err_o     = (state_q == S_ERROR);
  assign err_id_o  = err_id_q;

  a_wr_only_when_ready: assert property (@(posedge clk_i) disable iff (reset_i)
    (wr_v_i && wr_ready_o) |-> ((state_q == S_IDLE) || (state_q == S_ERROR)));

  a_err_busy_excl: assert property (@(posedge clk_i) disable iff (reset_i)
    !(err_o && busy_o));

endmodule

// File: tb/tb_bp_cfg_loader.sv
module tb_bp_cfg_loader;

  localparam int W  = 16;
  localparam int NF = 4;
  localparam int LG = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_v;
  logic [LG-1:0] wr_id;
  logic [W-1:0]  wr_data;
  logic          wr_commit;
  logic          wr_ready;
  logic [LG-1:0] rd_id;
  logic [W-1:0]  rd_data;
  logic          cfg_v;
  logic          busy;
  logic          err;
  logic [LG-1:0] err_id;

  int tests_run    = 0;
  int tests_failed = 0;
  int n;

  always #5 clk = ~clk;

  bp_cfg_loader #(
    .field_width_p (W),
    .num_fields_p  (NF),
    .nz_mask_p     (4'hF),
    .pow2_mask_p   (4'b0110)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_v_i      (wr_v),
    .wr_id_i     (wr_id),
    .wr_data_i   (wr_data),
    .wr_commit_i (wr_commit),
    .wr_ready_o  (wr_ready),
    .rd_id_i     (rd_id),
    .rd_data_o   (rd_data),
    .cfg_v_o     (cfg_v),
    .busy_o      (busy),
    .err_o       (err),
    .err_id_o    (err_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a write at a negedge, hold until accepted, return at the negedge after acceptance.
  task automatic do_write(input logic [LG-1:0] id, input logic [W-1:0] data, input logic commit);
    int waits;
    @(negedge clk);
    wr_v = 1'b1; wr_id = id; wr_data = data; wr_commit = commit;
    waits = 0;
    while (!wr_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) chk("wr_ready_wait", 32'd0, 32'd1);
    @(negedge clk);
    wr_v = 1'b0; wr_commit = 1'b0;
  endtask

  // Count further cycles until busy drops (bounded).
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    if (cycles >= 40) chk("busy_timeout", 32'd0, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [LG-1:0] id, input logic [W-1:0] exp);
    rd_id = id;
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_v = 1'b0; wr_id = '0; wr_data = '0; wr_commit = 1'b0; rd_id = 2'd1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cfg_v",  32'(cfg_v), 32'd0);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_err",    32'(err), 32'd0);
    chk("rst_err_id", 32'(err_id), 32'd0);
    chk("rst_ready",  32'(wr_ready), 32'd1);
    chk("rst_rd",     32'(rd_data), 32'd0);
    reset = 1'b0;

    // Full valid config: busy T+1..T+5, cfg_v at T+6
    do_write(2'd0, 16'd2, 1'b0);
    do_write(2'd1, 16'd64, 1'b0);
    do_write(2'd2, 16'd8, 1'b0);
    do_write(2'd3, 16'd512, 1'b1);
    rd_id = 2'd1;
    chk("t1_busy_T1",  32'(busy), 32'd1);
    chk("t1_ready_T1", 32'(wr_ready), 32'd0);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("t1_busy_T%0d", c), 32'(busy), 32'd1);
      chk($sformatf("t1_old_rd_T%0d", c), 32'(rd_data), 32'd0);
      chk($sformatf("t1_cfgv_T%0d", c), 32'(cfg_v), 32'd0);
    end
    @(negedge clk);
    chk("t1_busy_T6", 32'(busy), 32'd0);
    chk("t1_cfgv_T6", 32'(cfg_v), 32'd1);
    chk("t1_err",     32'(err), 32'd0);
    rd_chk("t1_rd1", 2'd1, 16'd64);
    rd_chk("t1_rd3", 2'd3, 16'd512);
    rd_chk("t1_rd0", 2'd0, 16'd2);

    // Field 1 = 48 is not a power of two -> error at k=1
    do_write(2'd0, 16'd2, 1'b0);
    do_write(2'd2, 16'd8, 1'b0);
    do_write(2'd3, 16'd512, 1'b0);
    do_write(2'd1, 16'd48, 1'b1);
    wait_idle(n);
    chk("t2_fail_lat", 32'(n), 32'd2);
    chk("t2_err",      32'(err), 32'd1);
    chk("t2_err_id",   32'(err_id), 32'd1);
    chk("t2_cfgv",     32'(cfg_v), 32'd1);
    chk("t2_ready",    32'(wr_ready), 32'd1);
    rd_chk("t2_rd1_old", 2'd1, 16'd64);

    // Corrective write from ERROR with commit
    do_write(2'd1, 16'd32, 1'b1);
    chk("t3_err_clr", 32'(err), 32'd0);
    chk("t3_busy",    32'(busy), 32'd1);
    wait_idle(n);
    chk("t3_pass_lat", 32'(n), 32'd5);
    chk("t3_err",      32'(err), 32'd0);
    chk("t3_cfgv",     32'(cfg_v), 32'd1);
    rd_chk("t3_rd1", 2'd1, 16'd32);

    // After reset, field 2 never written -> err_id 2, cfg_v 0
    do_reset();
    chk("t4_cfgv_rst", 32'(cfg_v), 32'd0);
    rd_chk("t4_rd1_rst", 2'd1, 16'd0);
    do_write(2'd0, 16'd2, 1'b0);
    do_write(2'd1, 16'd64, 1'b0);
    do_write(2'd3, 16'd512, 1'b1);
    wait_idle(n);
    chk("t4_fail_lat", 32'(n), 32'd3);
    chk("t4_err",      32'(err), 32'd1);
    chk("t4_err_id",   32'(err_id), 32'd2);
    chk("t4_cfgv",     32'(cfg_v), 32'd0);

    // Non-commit write leaves ERROR; then id0=0 fails nonzero check
    do_write(2'd2, 16'd8, 1'b0);
    chk("t5_err_clr",    32'(err), 32'd0);
    chk("t5_errid_clr",  32'(err_id), 32'd0);
    chk("t5_idle_busy",  32'(busy), 32'd0);
    do_write(2'd0, 16'd0, 1'b1);
    wait_idle(n);
    chk("t5_fail_lat", 32'(n), 32'd1);
    chk("t5_err",      32'(err), 32'd1);
    chk("t5_err_id",   32'(err_id), 32'd0);
    do_write(2'd0, 16'd5, 1'b0);
    do_write(2'd0, 16'd5, 1'b0);
    do_write(2'd0, 16'd3, 1'b1);
    wait_idle(n);
    chk("t5_pass_lat", 32'(n), 32'd5);
    chk("t5_err_ok",   32'(err), 32'd0);
    chk("t5_cfgv",     32'(cfg_v), 32'd1);
    rd_chk("t5_rd0", 2'd0, 16'd3);
    rd_chk("t5_rd2", 2'd2, 16'd8);

    // Reset in the middle of CHECK
    do_write(2'd0, 16'd7, 1'b0);
    do_write(2'd1, 16'd4, 1'b0);
    do_write(2'd2, 16'd16, 1'b0);
    do_write(2'd3, 16'd9, 1'b1);
    chk("t6_busy_T1", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    rd_id = 2'd0;
    @(negedge clk);
    chk("t6_cfgv",   32'(cfg_v), 32'd0);
    chk("t6_busy",   32'(busy), 32'd0);
    chk("t6_err",    32'(err), 32'd0);
    chk("t6_err_id", 32'(err_id), 32'd0);
    chk("t6_ready",  32'(wr_ready), 32'd1);
    chk("t6_rd0",    32'(rd_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
